// File: rtl/turbo_avst_pkg.sv
// Shared definitions for the turbo_sim Avalon-ST checkers: field positions,
// checker state encoding and the per-frame result record.
package turbo_avst_pkg;

    localparam int TREADY_B    = 29;
    localparam int START_B     = 27;
    localparam int KSHIFT_B    = 26;
    localparam int BITOUT_B    = 24;
    localparam int TOUT_LSB    = 16;
    localparam int ERR_LSB     = 0;
    localparam int ERR_FIELD_W = 7;
    localparam int IDX_W       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME  = 2'd1,
        RESULT = 2'd2
    } chk_state_t;

    typedef struct packed {
        logic [ERR_FIELD_W-1:0] counted;
        logic [ERR_FIELD_W-1:0] reported;
        logic                   match;
        logic                   short_f;
        logic                   sat;
    } chk_result_t;

    // A decoded bit error is a beat with both keepshift and bitout set.
    function automatic logic beat_has_err(input logic [31:0] data);
        return data[KSHIFT_B] & data[BITOUT_B];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating counter: optional clear, +1 increment and +value add in one cycle.
// Clear and increment together load 1, which starts a new count on the same beat.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         add_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;
    logic [W:0]   sum;

    // Next value: the sum is one bit wider so an overflow pins the count at all-ones.
    always_comb begin
        base = clr_i ? {W{1'b0}} : cnt_q;
        sum  = {1'b0, base} + {{W{1'b0}}, inc_i} + (add_i ? {1'b0, val_i} : {(W+1){1'b0}});
        if (sum[W]) begin
            cnt_d = {W{1'b1}};
        end else begin
            cnt_d = sum[W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/turbo_err_checker.sv
// Avalon-ST sink for asic_avalon_0 frames: counts decoded bit errors, compares them
// with the error count the ASIC reports, emits one result per frame, keeps statistics.
module turbo_err_checker
    import turbo_avst_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ERR_W      = ERR_FIELD_W,
    parameter int REPORT_IDX = 3,
    parameter int STAT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    input  logic              snk_sop,
    input  logic              snk_eop,
    output logic              snk_ready,
    input  logic              cfg_test_mode,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ERR_W-1:0]  res_counted,
    output logic [ERR_W-1:0]  res_reported,
    output logic              res_match,
    output logic              res_short,
    output logic              res_sat,
    output logic [STAT_W-1:0] stat_frames,
    output logic [STAT_W-1:0] stat_mismatch,
    output logic [STAT_W-1:0] stat_bit_err,
    output logic [STAT_W-1:0] stat_proto_err
);

    localparam logic [IDX_W-1:0] REP_IDX_C  = IDX_W'(REPORT_IDX);
    localparam logic             REP_AT_SOP = (REPORT_IDX == 0);

    chk_state_t        state_q, state_d;
    logic              snk_ready_q, snk_ready_d;
    logic              res_valid_q, res_valid_d;
    chk_result_t       res_q, res_d;
    logic              sat_q, sat_d;
    logic              cap_q, cap_d;
    logic [ERR_W-1:0]  rep_q, rep_d;
    logic [ERR_W-1:0]  cnt_q, cnt_fin;
    logic [IDX_W-1:0]  idx_q;
    logic [STAT_W-1:0] bit_err_add;
    logic              accept, start, fbeat, err_inc, rep_hit, done;
    logic              res_hs, proto_err, mism_inc, cnt_full;

    // A SOP in FRAME restarts exactly like a SOP in IDLE; only the protocol counter differs.
    assign accept      = snk_valid & snk_ready_q;
    assign start       = accept & snk_sop & (state_q != RESULT);
    assign fbeat       = accept & ~snk_sop & (state_q == FRAME);
    assign err_inc     = fbeat & beat_has_err(snk_data);
    assign rep_hit     = fbeat & (idx_q == REP_IDX_C);
    assign done        = (start | fbeat) & snk_eop;
    assign res_hs      = res_valid_q & res_ready;
    assign proto_err   = accept & (((state_q == IDLE) & snk_eop & ~snk_sop) |
                                   ((state_q == FRAME) & snk_sop));
    assign mism_inc    = res_hs & cfg_test_mode & ~res_q.match;
    assign cnt_full    = &cnt_q;
    assign cnt_fin     = start ? {ERR_W{1'b0}}
                               : cnt_q + {{(ERR_W-1){1'b0}}, (err_inc & ~cnt_full)};
    assign bit_err_add = {{(STAT_W-ERR_FIELD_W){1'b0}}, res_q.counted};

    sat_counter #(.W(ERR_W)) u_cnt (
        .clk(clk), .reset(reset), .clr_i(start), .inc_i(err_inc),
        .add_i(1'b0), .val_i({ERR_W{1'b0}}), .q_o(cnt_q)
    );
    sat_counter #(.W(IDX_W)) u_idx (
        .clk(clk), .reset(reset), .clr_i(start), .inc_i(start | fbeat),
        .add_i(1'b0), .val_i({IDX_W{1'b0}}), .q_o(idx_q)
    );
    sat_counter #(.W(STAT_W)) u_frames (
        .clk(clk), .reset(reset), .clr_i(1'b0), .inc_i(res_hs),
        .add_i(1'b0), .val_i({STAT_W{1'b0}}), .q_o(stat_frames)
    );
    sat_counter #(.W(STAT_W)) u_mism (
        .clk(clk), .reset(reset), .clr_i(1'b0), .inc_i(mism_inc),
        .add_i(1'b0), .val_i({STAT_W{1'b0}}), .q_o(stat_mismatch)
    );
    sat_counter #(.W(STAT_W)) u_bits (
        .clk(clk), .reset(reset), .clr_i(1'b0), .inc_i(1'b0),
        .add_i(res_hs), .val_i(bit_err_add), .q_o(stat_bit_err)
    );
    sat_counter #(.W(STAT_W)) u_proto (
        .clk(clk), .reset(reset), .clr_i(1'b0), .inc_i(proto_err),
        .add_i(1'b0), .val_i({STAT_W{1'b0}}), .q_o(stat_proto_err)
    );

    // State and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            snk_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            snk_ready_q <= snk_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = snk_eop ? RESULT : FRAME;
                end else begin
                    state_d = IDLE;
                end
            end
            FRAME: begin
                if (done) begin
                    state_d = RESULT;
                end else begin
                    state_d = FRAME;
                end
            end
            RESULT: begin
                if (res_hs) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESULT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the next state so they are valid from the first cycle in that state.
    always_comb begin
        snk_ready_d = (state_d != RESULT);
        res_valid_d = (state_d == RESULT);
    end

    // Per-frame saturation and report capture.
    always_comb begin
        sat_d = sat_q;
        cap_d = cap_q;
        rep_d = rep_q;
        if (start) begin
            sat_d = 1'b0;
            cap_d = REP_AT_SOP;
            rep_d = REP_AT_SOP ? snk_data[ERR_LSB +: ERR_W] : {ERR_W{1'b0}};
        end else if (fbeat) begin
            sat_d = sat_q | (err_inc & cnt_full);
            if (rep_hit) begin
                cap_d = 1'b1;
                rep_d = snk_data[ERR_LSB +: ERR_W];
            end else begin
                cap_d = cap_q;
                rep_d = rep_q;
            end
        end else begin
            sat_d = sat_q;
        end
    end

    // The result record is built from the values the EOP beat itself produces.
    always_comb begin
        res_d = res_q;
        if (done) begin
            res_d.counted  = cnt_fin;
            res_d.reported = cap_d ? rep_d : {ERR_W{1'b0}};
            res_d.match    = cap_d & ~sat_d & (cnt_fin == rep_d);
            res_d.short_f  = ~cap_d;
            res_d.sat      = sat_d;
        end else begin
            res_d = res_q;
        end
    end

    // Per-frame registers and the held result record.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
            cap_q <= 1'b0;
            rep_q <= {ERR_W{1'b0}};
            res_q <= '{default: 1'b0};
        end else begin
            sat_q <= sat_d;
            cap_q <= cap_d;
            rep_q <= rep_d;
            res_q <= res_d;
        end
    end

    assign snk_ready    = snk_ready_q;
    assign res_valid    = res_valid_q;
    assign res_counted  = res_q.counted;
    assign res_reported = res_q.reported;
    assign res_match    = res_q.match;
    assign res_short    = res_q.short_f;
    assign res_sat      = res_q.sat;

endmodule

// File: tb/tb_turbo_err_checker.sv
// Self-checking bench for turbo_err_checker: directed frames plus randomized traffic
// checked against a frame-level reference model.
module tb_turbo_err_checker;

    localparam int REP  = 3;
    localparam int EMAX = 127;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] snk_data;
    logic        snk_valid, snk_sop, snk_eop, snk_ready;
    logic        cfg_test_mode, res_valid, res_ready;
    logic [6:0]  res_counted, res_reported;
    logic        res_match, res_short, res_sat;
    logic [31:0] stat_frames, stat_mismatch, stat_bit_err, stat_proto_err;

    always #5 clk = ~clk;

    turbo_err_checker dut (
        .clk(clk), .reset(reset), .snk_data(snk_data), .snk_valid(snk_valid),
        .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_ready(snk_ready),
        .cfg_test_mode(cfg_test_mode), .res_valid(res_valid), .res_ready(res_ready),
        .res_counted(res_counted), .res_reported(res_reported), .res_match(res_match),
        .res_short(res_short), .res_sat(res_sat), .stat_frames(stat_frames),
        .stat_mismatch(stat_mismatch), .stat_bit_err(stat_bit_err),
        .stat_proto_err(stat_proto_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic finish_sim();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    endtask

    // ---------------- reference model (frame level) ----------------
    typedef struct {
        int counted;
        int reported;
        bit match;
        bit short_f;
        bit sat;
    } exp_t;

    exp_t   exp_q[$];
    bit     m_in;
    int     m_cnt, m_idx, m_rep;
    bit     m_cap;
    longint m_frames, m_mism, m_bits, m_proto;

    function automatic void model_reset();
        m_in = 0; m_cnt = 0; m_idx = 0; m_rep = 0; m_cap = 0;
        m_frames = 0; m_mism = 0; m_bits = 0; m_proto = 0;
        exp_q.delete();
    endfunction

    function automatic void model_beat(input logic [31:0] d, input bit sop, input bit eop);
        exp_t e;
        if (sop) begin
            if (m_in) m_proto++;
            m_in = 1; m_cnt = 0; m_idx = 0; m_cap = 0; m_rep = 0;
        end else if (!m_in) begin
            if (eop) m_proto++;
            return;
        end else if (d[26] && d[24]) begin
            m_cnt++;
        end
        if (m_idx == REP) begin
            m_cap = 1;
            m_rep = int'(d[6:0]);
        end
        m_idx++;
        if (eop) begin
            e.counted  = (m_cnt > EMAX) ? EMAX : m_cnt;
            e.sat      = (m_cnt > EMAX);
            e.short_f  = !m_cap;
            e.reported = m_cap ? m_rep : 0;
            e.match    = m_cap && (m_cnt <= EMAX) && (m_cnt == m_rep);
            exp_q.push_back(e);
            m_in = 0;
        end
    endfunction

    // ---------------- result consumer and monitor ----------------
    int         rr_mode   = 0;   // 0: always ready, 1: ~40% idle, 2: held off
    int         n_results = 0;
    logic [6:0] last_cnt, last_rep;
    logic       last_match, last_short, last_sat;

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ($urandom_range(0, 99) >= 40);
                default: res_ready = 1'b0;
            endcase
        end
    end

    initial begin
        bit          pend;
        logic [16:0] held;
        exp_t        e;
        pend = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 0;
            end else if (res_valid) begin
                if (pend)
                    check_val("res_stable", {res_counted, res_reported, res_match, res_short, res_sat}, held);
                if (res_ready) begin
                    pend = 0;
                    check_val("result_expected", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_val("res_counted", res_counted, e.counted);
                        check_val("res_reported", res_reported, e.reported);
                        check_val("res_match", res_match, e.match);
                        check_val("res_short", res_short, e.short_f);
                        check_val("res_sat", res_sat, e.sat);
                        m_frames++;
                        m_bits += e.counted;
                        if (cfg_test_mode && !e.match) m_mism++;
                    end
                    n_results++;
                    last_cnt = res_counted; last_rep = res_reported;
                    last_match = res_match; last_short = res_short; last_sat = res_sat;
                end else begin
                    pend = 1;
                    held = {res_counted, res_reported, res_match, res_short, res_sat};
                end
            end else begin
                pend = 0;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    bit idle_en = 0;

    task automatic send_beat(input logic [31:0] d, input bit sop, input bit eop);
        int guard;
        if (idle_en) begin
            while ($urandom_range(0, 99) < 40) begin
                snk_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        snk_data = d; snk_sop = sop; snk_eop = eop; snk_valid = 1'b1;
        guard = 0;
        while (!snk_ready && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) begin
            check_val("ready_wait", snk_ready, 1);
            finish_sim();
        end
        @(posedge clk);
        #1;
        model_beat(d, sop, eop);
        snk_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int n_err, input int rep_val, input bit with_eop);
        for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i > 0) begin
                if (i >= n - n_err) begin
                    d[26] = 1'b1; d[24] = 1'b1;
                end else if (d[26]) begin
                    d[24] = 1'b0;
                end
            end
            if (i == REP) d[6:0] = 7'(rep_val);
            send_beat(d, (i == 0), with_eop && (i == n - 1));
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || res_valid) && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_val("drain", exp_q.size(), 0);
    endtask

    initial begin
        int          r0, g, n, ne, rv, kind;
        logic [31:0] pd;
        reset = 1'b1; snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
        snk_data = 32'd0; cfg_test_mode = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_snk_ready", snk_ready, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_res_fields", {res_counted, res_reported, res_match, res_short, res_sat}, 0);
        check_val("rst_stats", {stat_frames, stat_mismatch, stat_bit_err, stat_proto_err}, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("ready_after_reset", snk_ready, 1);
        @(posedge clk); #1;

        // 1: clean comparison
        send_frame(202, 5, 5, 1); drain();
        check_val("t1_counted", last_cnt, 5);
        check_val("t1_reported", last_rep, 5);
        check_val("t1_match", last_match, 1);
        check_val("t1_mismatch", stat_mismatch, 0);
        // 2: reported value disagrees
        send_frame(202, 5, 4, 1); drain();
        check_val("t2_match", last_match, 0);
        check_val("t2_mismatch", stat_mismatch, 1);
        check_val("t2_frames", stat_frames, 2);
        // 3: saturation
        send_frame(202, 200, 9, 1); drain();
        check_val("t3_counted", last_cnt, 127);
        check_val("t3_sat", last_sat, 1);
        check_val("t3_match", last_match, 0);
        check_val("t3_bit_err", stat_bit_err, 137);
        // 4: SOP mid-frame discards the partial frame
        r0 = n_results;
        send_frame(50, 0, 0, 0);
        send_frame(202, 0, 0, 1); drain();
        check_val("t4_proto", stat_proto_err, 1);
        check_val("t4_results", n_results - r0, 1);
        check_val("t4_counted", last_cnt, 0);
        // 5: short frame, then orphan EOP
        send_frame(3, 0, 0, 1); drain();
        check_val("t5_short", last_short, 1);
        check_val("t5_reported", last_rep, 0);
        r0 = n_results;
        send_beat($urandom, 0, 1);
        repeat (4) @(posedge clk);
        #1; drain();
        check_val("t5_orphan_proto", stat_proto_err, 2);
        check_val("t5_orphan_results", n_results - r0, 0);

        // 6: consumer back-pressure with a beat waiting
        rr_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_frame(5, 1, 1, 1);
        pd = $urandom;
        snk_data = pd; snk_sop = 1'b1; snk_eop = 1'b1; snk_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("t6_ready_held", snk_ready, 0);
            check_val("t6_valid_held", res_valid, 1);
        end
        rr_mode = 0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(res_valid && res_ready) && g < 10);
        check_val("t6_hs_seen", (res_valid && res_ready), 1);
        check_val("t6_ready_at_hs", snk_ready, 0);
        @(negedge clk);
        check_val("t6_ready_after_hs", snk_ready, 1);
        @(posedge clk);
        #1;
        model_beat(pd, 1, 1);
        snk_valid = 1'b0;
        drain();
        check_val("t6_frames", stat_frames, m_frames);

        // reset while a result is pending
        rr_mode = 2;
        send_frame(4, 0, 0, 1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("rst_mid_valid", res_valid, 0);
        check_val("rst_mid_ready", snk_ready, 0);
        check_val("rst_mid_stats", {stat_frames, stat_proto_err}, 0);
        model_reset();
        @(posedge clk); #1; reset = 1'b0; rr_mode = 0;
        @(posedge clk); #1;

        // randomized traffic
        idle_en = 1; rr_mode = 1;
        for (int f = 0; f < 860; f++) begin
            cfg_test_mode = 1'($urandom);
            kind = $urandom_range(0, 99);
            if (kind < 5) begin
                send_beat($urandom, 0, 1);
            end else if (kind < 8) begin
                send_beat($urandom, 0, 0);
            end else begin
                if (kind < 14) send_frame($urandom_range(1, 20), 0, 0, 0);
                if (kind < 19) begin
                    n  = $urandom_range(128, 160);
                    ne = $urandom_range(120, n - 1);
                end else begin
                    n  = $urandom_range(1, 40);
                    ne = (n > 1) ? $urandom_range(0, n - 1) : 0;
                end
                rv = $urandom_range(0, 1) ? ((ne > EMAX) ? EMAX : ne) : $urandom_range(0, EMAX);
                send_frame(n, ne, rv, 1);
            end
        end
        idle_en = 0; rr_mode = 0;
        drain();
        check_val("final_frames", stat_frames, m_frames);
        check_val("final_mismatch", stat_mismatch, m_mism);
        check_val("final_bit_err", stat_bit_err, m_bits);
        check_val("final_proto", stat_proto_err, m_proto);
        finish_sim();
    end

endmodule
